// File: rtl/comparator_sched_pkg.sv
// Shared types and defaults for the comparator scheduler: FSM states,
// default sizing and the requester-id width helper.
package comparator_sched_pkg;

   localparam int unsigned N_REQ_DEF    = 4;
   localparam int unsigned DW_DEF       = 16;
   localparam int unsigned COMP_LAT_DEF = 2;
   localparam int unsigned CNT_W        = 4;

   // Requester index width; a single requester still needs one bit.
   function automatic int unsigned id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned ID_W_DEF = id_w(N_REQ_DEF);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/comparator_scheduler_if.sv
// Request, datapath and response signals of the comparator scheduler.
// slave = scheduler side, master = requesters plus comparator datapath.
interface comparator_scheduler_if #(
   parameter int unsigned N_REQ = comparator_sched_pkg::N_REQ_DEF,
   parameter int unsigned DW    = comparator_sched_pkg::DW_DEF
);
   localparam int unsigned IDW = comparator_sched_pkg::id_w(N_REQ);

   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*DW-1:0] req_pivot;
   logic [N_REQ*DW-1:0] req_lbp1;
   logic [N_REQ*DW-1:0] req_lbp2;
   logic [N_REQ-1:0]    req_minmax;

   logic [DW-1:0]       dp_pivot_x;
   logic [DW-1:0]       dp_lbp1_max;
   logic [DW-1:0]       dp_lbp2_min;
   logic                dp_minmax_on;
   logic                dp_lbp1_out;
   logic                dp_lbp2_out;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic                rsp_lbp1;
   logic                rsp_lbp2;

   modport slave (
      input  req_valid, req_pivot, req_lbp1, req_lbp2, req_minmax,
      output req_ready,
      output dp_pivot_x, dp_lbp1_max, dp_lbp2_min, dp_minmax_on,
      input  dp_lbp1_out, dp_lbp2_out,
      output rsp_valid, rsp_id, rsp_lbp1, rsp_lbp2,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_pivot, req_lbp1, req_lbp2, req_minmax,
      input  req_ready,
      input  dp_pivot_x, dp_lbp1_max, dp_lbp2_min, dp_minmax_on,
      output dp_lbp1_out, dp_lbp2_out,
      input  rsp_valid, rsp_id, rsp_lbp1, rsp_lbp2,
      output rsp_ready
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping at N_REQ-1, returned as one-hot grant plus index.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   winner
);

   always_comb begin
      int unsigned    sum;
      logic [IDW-1:0] idx;
      grant  = '0;
      winner = '0;
      sum    = 0;
      idx    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         sum = 32'(ptr) + k;
         if (sum >= N_REQ) sum = sum - N_REQ;
         idx = IDW'(sum);
         if (grant == '0 && req[idx]) begin
            grant[idx] = 1'b1;
            winner     = idx;
         end
      end
   end

endmodule

// File: rtl/comparator_scheduler.sv
// Time-shares one comparator datapath among N_REQ requesters: round-robin
// grant, fixed-latency issue/wait, then a backpressured response.
module comparator_scheduler
   import comparator_sched_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned COMP_LAT = COMP_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   comparator_scheduler_if.slave bus,
   output logic                 busy
);

   localparam int unsigned IDW = id_w(N_REQ);

   state_t           state, state_nx;
   logic [IDW-1:0]   ptr, ptr_nx;
   logic [IDW-1:0]   winner;
   logic [N_REQ-1:0] grant;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [DW-1:0]    pivot_q, pivot_nx, lbp1_q, lbp1_nx, lbp2_q, lbp2_nx;
   logic             minmax_q, minmax_nx;
   logic [IDW-1:0]   rsp_id_q, rsp_id_nx;
   logic             rsp_valid_q, rsp_valid_nx;
   logic             rsp_lbp1_q, rsp_lbp1_nx, rsp_lbp2_q, rsp_lbp2_nx;
   logic             busy_q, busy_nx;

   rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
      .req    (bus.req_valid),
      .ptr    (ptr),
      .grant  (grant),
      .winner (winner)
   );

   // Grant is an accept strobe in the same cycle the request is seen.
   assign bus.req_ready = (reset && state == S_IDLE) ? grant : '0;

   // Next-state and next-output logic.
   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      cnt_nx      = cnt;
      pivot_nx    = pivot_q;
      lbp1_nx     = lbp1_q;
      lbp2_nx     = lbp2_q;
      minmax_nx   = minmax_q;
      rsp_id_nx   = rsp_id_q;
      rsp_lbp1_nx = rsp_lbp1_q;
      rsp_lbp2_nx = rsp_lbp2_q;

      case (state)
         S_IDLE: begin
            if (|bus.req_valid) begin
               state_nx  = S_ISSUE;
               ptr_nx    = (32'(winner) == N_REQ - 1) ? '0 : IDW'(32'(winner) + 32'd1);
               pivot_nx  = bus.req_pivot[32'(winner)*DW +: DW];
               lbp1_nx   = bus.req_lbp1[32'(winner)*DW +: DW];
               lbp2_nx   = bus.req_lbp2[32'(winner)*DW +: DW];
               minmax_nx = bus.req_minmax[winner];
               rsp_id_nx = winner;
            end
         end
         S_ISSUE: begin
            cnt_nx   = CNT_W'(COMP_LAT - 1);
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (cnt == '0) begin
               rsp_lbp1_nx = bus.dp_lbp1_out;
               rsp_lbp2_nx = bus.dp_lbp2_out;
               state_nx    = S_RESP;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_RESP: begin
            // Operands are released only once the response is taken.
            if (bus.rsp_ready) begin
               state_nx  = S_IDLE;
               pivot_nx  = '0;
               lbp1_nx   = '0;
               lbp2_nx   = '0;
               minmax_nx = 1'b0;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      rsp_valid_nx = (state_nx == S_RESP);
      busy_nx      = (state_nx != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         ptr         <= '0;
         cnt         <= '0;
         pivot_q     <= '0;
         lbp1_q      <= '0;
         lbp2_q      <= '0;
         minmax_q    <= 1'b0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_lbp1_q  <= 1'b0;
         rsp_lbp2_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         cnt         <= cnt_nx;
         pivot_q     <= pivot_nx;
         lbp1_q      <= lbp1_nx;
         lbp2_q      <= lbp2_nx;
         minmax_q    <= minmax_nx;
         rsp_id_q    <= rsp_id_nx;
         rsp_valid_q <= rsp_valid_nx;
         rsp_lbp1_q  <= rsp_lbp1_nx;
         rsp_lbp2_q  <= rsp_lbp2_nx;
         busy_q      <= busy_nx;
      end
   end

   assign bus.dp_pivot_x   = pivot_q;
   assign bus.dp_lbp1_max  = lbp1_q;
   assign bus.dp_lbp2_min  = lbp2_q;
   assign bus.dp_minmax_on = minmax_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_lbp1     = rsp_lbp1_q;
   assign bus.rsp_lbp2     = rsp_lbp2_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_comparator_scheduler.sv
// Bench for comparator_scheduler: transaction-level model with per-cycle
// comparison, directed scenarios and randomized traffic with resets.
module tb_comparator_scheduler;

   localparam int N        = 4;
   localparam int DW       = 16;
   localparam int COMP_LAT = 2;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   comparator_scheduler_if #(.N_REQ(N), .DW(DW)) bus ();

   comparator_scheduler #(.N_REQ(N), .DW(DW), .COMP_LAT(COMP_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Comparator behaviour used by the datapath stand-in.
   function automatic logic [1:0] dp_fn(input logic [DW-1:0] p, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic mm);
      logic r1, r2;
      r1 = mm ? (p > a) : (p < a);
      r2 = mm ? (p < b) : (p > b);
      return {r1, r2};
   endfunction

   // Datapath stand-in: results are correct only COMP_LAT cycles after issue.
   int         bc;
   logic [1:0] dp_res;
   always @(posedge clk or negedge reset) begin
      if (!reset)    bc <= 0;
      else if (busy) bc <= bc + 1;
      else           bc <= 0;
   end
   assign dp_res          = dp_fn(bus.dp_pivot_x, bus.dp_lbp1_max, bus.dp_lbp2_min, bus.dp_minmax_on);
   assign bus.dp_lbp1_out = (bc == COMP_LAT) ? dp_res[1] : ~dp_res[1];
   assign bus.dp_lbp2_out = (bc == COMP_LAT) ? dp_res[0] : ~dp_res[0];

   // Model: at most one transaction, aged in cycles from its issue cycle.
   int            m_ptr = 0;
   bit            m_busy = 0;
   int            m_g, m_id;
   logic [DW-1:0] m_piv, m_l1, m_l2;
   logic          m_mm;
   int            g_id[$], g_cyc[$], r_id[$];

   always @(negedge clk) begin
      logic [N-1:0] exp_ready;
      int           widx, age, gi;
      logic [1:0]   f;
      bit           exp_rv;
      if (|bus.req_ready) begin
         gi = 0;
         for (int i = 0; i < N; i++) if (((bus.req_ready >> i) & 4'd1) != 4'd0) gi = i;
         g_id.push_back(gi);
         g_cyc.push_back(cyc);
      end
      if (bus.rsp_valid && bus.rsp_ready) r_id.push_back(int'(bus.rsp_id));

      if (!reset) begin
         check("reset_outputs",
               64'({bus.req_ready, busy, bus.rsp_valid, bus.rsp_id, bus.rsp_lbp1, bus.rsp_lbp2,
                    bus.dp_pivot_x, bus.dp_lbp1_max, bus.dp_lbp2_min, bus.dp_minmax_on}), 64'd0);
         m_busy = 0;
         m_ptr  = 0;
      end else if (!m_busy) begin
         widx = -1;
         for (int k = 0; k < N; k++)
            if (widx < 0 && ((bus.req_valid >> ((m_ptr + k) % N)) & 4'd1) != 4'd0)
               widx = (m_ptr + k) % N;
         exp_ready = (widx >= 0) ? (4'd1 << widx) : 4'd0;
         check("req_ready_idle", 64'(bus.req_ready), 64'(exp_ready));
         check("busy_idle", 64'(busy), 64'd0);
         check("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
         check("dp_idle", 64'({bus.dp_pivot_x, bus.dp_lbp1_max, bus.dp_lbp2_min, bus.dp_minmax_on}), 64'd0);
         if (widx >= 0) begin
            m_busy = 1;
            m_id   = widx;
            m_g    = cyc + 1;
            m_ptr  = (widx + 1) % N;
            m_piv  = bus.req_pivot[widx*DW +: DW];
            m_l1   = bus.req_lbp1[widx*DW +: DW];
            m_l2   = bus.req_lbp2[widx*DW +: DW];
            m_mm   = bus.req_minmax[widx];
         end
      end else begin
         age    = cyc - m_g;
         exp_rv = (age >= COMP_LAT + 1);
         check("req_ready_busy", 64'(bus.req_ready), 64'd0);
         check("busy_flag", 64'(busy), 64'd1);
         check("dp_operands", 64'({bus.dp_pivot_x, bus.dp_lbp1_max, bus.dp_lbp2_min, bus.dp_minmax_on}),
               64'({m_piv, m_l1, m_l2, m_mm}));
         check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
         if (exp_rv) begin
            f = dp_fn(m_piv, m_l1, m_l2, m_mm);
            check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            check("rsp_bits", 64'({bus.rsp_lbp1, bus.rsp_lbp2}), 64'(f));
            if (bus.rsp_ready) m_busy = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int id, input int budget, output int gcyc);
      bit hit = 0;
      gcyc = -1;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (((bus.req_ready >> id) & 4'd1) != 4'd0) begin
            hit  = 1;
            gcyc = cyc;
         end
      end
      check("grant_seen", 64'(hit), 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      bit hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (!busy && !bus.rsp_valid) hit = 1;
      end
      check("idle_seen", 64'(hit), 64'd1);
   endtask

   task automatic rand_ops();
      bus.req_pivot = {$urandom, $urandom};
      bus.req_lbp1  = {$urandom, $urandom};
      bus.req_lbp2  = {$urandom, $urandom};
   endtask

   initial begin
      int gc, rc, gmark, rmark, rel_cyc, held, cnt3;
      bit hit;
      reset          = 1'b0;
      bus.req_valid  = '0;
      bus.req_pivot  = '0;
      bus.req_lbp1   = '0;
      bus.req_lbp2   = '0;
      bus.req_minmax = '0;
      bus.rsp_ready  = 1'b1;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      reset = 1'b1;

      // Single request from requester 2.
      bus.req_valid           = 4'b0100;
      bus.req_pivot[2*DW +: DW] = 16'h0040;
      bus.req_lbp1[2*DW +: DW]  = 16'h0080;
      bus.req_lbp2[2*DW +: DW]  = 16'h0010;
      wait_grant(2, 10, gc);
      tick();
      bus.req_valid = '0;
      hit = 0;
      rc  = -1;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            hit = 1;
            rc  = cyc;
            check("t1_rsp_id", 64'(bus.rsp_id), 64'd2);
            check("t1_rsp_bits", 64'({bus.rsp_lbp1, bus.rsp_lbp2}), 64'b11);
         end
      end
      check("t1_latency", 64'(rc - gc), 64'd4);
      wait_idle(10);

      // Reset during WAIT, then all requesters valid from pointer 0.
      tick();
      rand_ops();
      bus.req_valid = 4'b0010;
      wait_grant(1, 10, gc);
      tick();
      bus.req_valid = '0;
      tick();
      bus.req_valid = 4'b1111;
      reset = 1'b0;
      #1;
      check("t2_rst_busy", 64'(busy), 64'd0);
      check("t2_rst_ready", 64'(bus.req_ready), 64'd0);
      check("t2_rst_dp", 64'(bus.dp_pivot_x), 64'd0);
      check("t2_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      tick();
      tick();
      reset   = 1'b1;
      rel_cyc = cyc;
      gmark   = g_id.size();
      rmark   = r_id.size();
      for (int i = 0; i < 60 && g_id.size() < gmark + 5; i++) @(negedge clk);
      check("t2_grants_seen", 64'(g_id.size() >= gmark + 5), 64'd1);
      if (g_id.size() >= gmark + 5) begin
         check("t2_first_grant_cycle", 64'(g_cyc[gmark]), 64'(rel_cyc));
         for (int j = 0; j < 5; j++) check("t2_grant_order", 64'(g_id[gmark+j]), 64'(j % N));
         for (int j = 1; j < 5; j++) check("t2_grant_spacing", 64'(g_cyc[gmark+j] - g_cyc[gmark+j-1]), 64'd5);
      end
      tick();
      bus.req_valid = '0;
      wait_idle(30);
      check("t2_rsp_count", 64'(r_id.size() > rmark), 64'd1);
      if (r_id.size() > rmark) check("t2_first_rsp_id", 64'(r_id[rmark]), 64'd0);

      // Backpressure held for 10 cycles in RESP.
      tick();
      rand_ops();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) hit = 1;
      end
      check("t3_rsp_seen", 64'(hit), 64'd1);
      tick();
      gmark = g_id.size();
      held  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) held++;
      end
      check("t3_rsp_held", 64'(held), 64'd10);
      check("t3_no_grant", 64'(g_id.size() - gmark), 64'd0);
      tick();
      bus.rsp_ready = 1'b1;
      bus.req_valid = '0;
      wait_idle(20);

      // Mode bit from requester 1 only.
      tick();
      rand_ops();
      bus.req_minmax = 4'b0010;
      bus.req_valid  = 4'b1111;
      repeat (22) tick();
      bus.req_valid = '0;
      wait_idle(20);
      tick();
      bus.req_minmax = '0;

      // Requester 3 withdraws while requester 1 is served.
      bus.req_valid = 4'b0010;
      wait_grant(1, 10, gc);
      tick();
      gmark = g_id.size();
      rmark = r_id.size();
      bus.req_valid = 4'b1000;
      tick();
      tick();
      bus.req_valid = '0;
      wait_idle(20);
      repeat (3) tick();
      cnt3 = 0;
      for (int j = gmark; j < g_id.size(); j++) if (g_id[j] == 3) cnt3++;
      for (int j = rmark; j < r_id.size(); j++) if (r_id[j] == 3) cnt3++;
      check("t5_req3_never_served", 64'(cnt3), 64'd0);

      // Randomized traffic with backpressure and two mid-stream resets.
      for (int i = 0; i < 400; i++) begin
         tick();
         if (i == 150 || i == 300) reset = 1'b0;
         if (i == 152 || i == 302) reset = 1'b1;
         bus.req_valid  = 4'($urandom);
         bus.req_minmax = 4'($urandom);
         rand_ops();
         bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      end
      tick();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      wait_idle(30);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/comparator_scheduler.md
COMPARATOR_SCHEDULER -- requirements
Module: comparator_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the comparator datapath.
REQ-002 Parameter DW, default 16, operand width of pivot and LBP operands.
REQ-003 Parameter COMP_LAT, default 2, datapath latency in cycles from operand present to result valid (range 1..15).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  N_REQ  per-requester request valid.
REQ-007 req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
REQ-008 req_pivot  input  N_REQ*DW  packed pivot operands, requester i at bits [i*DW +: DW].
REQ-009 req_lbp1  input  N_REQ*DW  packed LBP1 (max) operands.
REQ-010 req_lbp2  input  N_REQ*DW  packed LBP2 (min) operands.
REQ-011 req_minmax  input  N_REQ  per-requester minmax_on mode bit.
REQ-012 dp_pivot_x, dp_lbp1_max, dp_lbp2_min  output  DW each  operands driven to comparator datapath.
REQ-013 dp_minmax_on  output  1  mode bit to datapath.
REQ-014 dp_lbp1_out, dp_lbp2_out  input  1 each  datapath result bits.
REQ-015 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-016 rsp_id  output  clog2(N_REQ)  index of requester owning the response.
REQ-017 rsp_lbp1, rsp_lbp2  output  1 each  captured result bits.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; single transaction in flight at any time.
REQ-020 IDLE: if any req_valid, grant the round-robin winner, assert req_ready for that requester for exactly that cycle, register its operands, id and mode, go to ISSUE; else stay.
REQ-021 Round-robin: search starts at pointer; after a grant to i, pointer becomes (i+1) mod N_REQ; pointer resets to 0.
REQ-022 req_ready is zero in every state other than IDLE and in IDLE when no req_valid.
REQ-023 ISSUE: registered operands appear on dp_* outputs; load wait counter with COMP_LAT-1; go to WAIT next cycle.
REQ-024 WAIT: decrement counter each cycle; on the cycle counter equals 0, capture dp_lbp1_out/dp_lbp2_out into rsp_lbp1/rsp_lbp2 and go to RESP.
REQ-025 dp_* outputs hold stable from ISSUE through end of RESP; no operand change while a transaction is in flight.
REQ-026 RESP: rsp_valid high; rsp_id, rsp_lbp1, rsp_lbp2 stable until rsp_ready sampled high; then go to IDLE.
REQ-027 rsp_ready high on first RESP cycle: RESP lasts one cycle; next grant possible the following IDLE cycle; minimum transaction period COMP_LAT+3 cycles.
REQ-028 rsp_ready low: stay in RESP indefinitely, no new grants (backpressure).
REQ-029 Requester that drops req_valid before grant is simply not served; no state retained for it.
REQ-030 All requesters valid simultaneously: served in strict order pointer, pointer+1, ... wrapping at N_REQ-1 to 0.

Reset
REQ-031 reset low: state IDLE, pointer 0, counter 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_lbp1 0, rsp_lbp2 0, dp_* 0, dp_minmax_on 0, busy 0, immediately and asynchronously.
REQ-032 Reset mid-transaction discards the in-flight request; no response is ever produced for it.
REQ-033 Reset deassertion is synchronous to clk; first grant possible on the first rising edge after deassertion.

Structure
REQ-034 Shared package comparator_sched_pkg holds the state enumeration, default N_REQ, DW, COMP_LAT and the id-width constant.
REQ-035 Arbitration is a sub-module rr_arbiter (inputs requests, pointer; outputs one-hot grant and winner index), combinational.

Verification
REQ-036 Single request: req_valid[2]=1, pivot 0x0040, lbp1 0x0080, lbp2 0x0010, COMP_LAT=2, rsp_ready=1 -> req_ready[2] one cycle, rsp_valid 4 cycles later with rsp_id=2 and rsp bits equal to datapath outputs.
REQ-037 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 each COMP_LAT+3=5 cycles apart.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and payload stable, req_ready stays 0, dp_* unchanged.
REQ-039 Reset asserted during WAIT -> all outputs 0 at once, no rsp_valid after release, next grant starts from requester 0.
REQ-040 Mode pass-through: req_minmax[1]=1, others 0 -> dp_minmax_on=1 only during requester 1 transaction.
REQ-041 Requester 3 drops req_valid while requester 1 served -> requester 3 never granted, no response with rsp_id=3.
